divider_block: RTL and testbench
================================

Name: divider_block

Overview:
- Sequential 64-bit integer divider: the inverse-direction companion to the Booth radix-4 multiplier block in the same arithmetic unit.
- Radix-2 non-restoring algorithm. Produces quotient and remainder from a dividend and divisor.
- Operands are captured on a start pulse. Completion is signalled with a done level held until the next start.
- Sits beside the multiplier in the ALU datapath. Driven by the same control FSM.

Parameters:
WIDTH, 64, operand/quotient/remainder width in bits.
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request; sampled only in IDLE or DONE.
dividend  input  WIDTH  numerator, captured when start is accepted.
divisor  input  WIDTH  denominator, captured when start is accepted.
busy  output  1  high while in RUN or FIX.
done  output  1  high in DONE; quotient/remainder valid.
div_by_zero  output  1  high with done when captured divisor == 0.
quotient  output  WIDTH  result quotient.
remainder  output  WIDTH  result remainder.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
  - Internal partial remainder, quotient shift register and counter cleared.
  - Reset mid-operation aborts; no partial result is exposed.
- States:
  - IDLE -> RUN: on start with divisor!=0.
  - IDLE -> DONE: on start with divisor==0 (div-by-zero path).
  - RUN -> FIX: when counter reaches WIDTH-1.
  - FIX -> DONE: unconditionally.
  - DONE -> RUN or DONE: on start, under the same divisor rule as IDLE.
  - DONE holds otherwise.
- Start acceptance:
  - start is honoured only in IDLE/DONE.
  - start while busy is ignored; operands are not re-captured.
  - Operand changes after capture have no effect.
- Accept cycle:
  - Partial remainder P (WIDTH+1 bits, signed) is cleared.
  - Q is loaded with |dividend|.
  - D is loaded with |divisor|.
  - Counter is set to 0.
  - done and div_by_zero drop to 0.
- RUN, one iteration per cycle, exactly WIDTH cycles:
  - {P,Q} shifted left 1.
  - If the previous P was >= 0, P = P - D; otherwise P = P + D.
  - Q[0] = ~P_new[WIDTH].
- FIX, 1 cycle:
  - If P < 0, P = P + D.
  - Apply signs: quotient is negated if the operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
  - quotient/remainder registers are written.
- Latency:
  - start sampled at edge 0.
  - done rises after edge WIDTH+2, i.e. 66 cycles for WIDTH=64.
  - Div-by-zero: done rises after edge 1.
- Divide by zero:
  - quotient = all ones.
  - remainder = dividend unchanged.
  - div_by_zero = 1.
- Signed overflow (dividend = most-negative value, divisor = -1): quotient = most-negative value, remainder = 0, no flag. The natural datapath yields this; the WIDTH+1 bit P prevents wrap.
- Outputs are registered. quotient/remainder hold their last value through a new RUN; they are valid only while done=1.
- Simultaneous start and reset: reset wins.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's-complement.
  - Magnitudes are taken at capture; sign fixup happens in FIX as above.
- Undefined:
  - Operands are unsigned.
  - No negation logic.
  - FIX only restores P.
  - The signed-overflow case does not exist.
- Latency is identical in both builds.

Decomposition:
- Shared package (alongside the multiplier constants) holds:
  - State encodings: DIV_IDLE=2'b00, DIV_RUN=2'b01, DIV_FIX=2'b10, DIV_DONE=2'b11.
  - DIV_WIDTH default.
  - DIV_ZERO_QUOTIENT constant (all ones).
- One natural sub-module: divider_step.
  - Combinational single non-restoring iteration.
  - Inputs: P, Q MSB, D.
  - Outputs: next P, quotient bit.
  - Instantiated once inside the RUN datapath.
- The iteration counter is inline.

Test Plan:
1. Unsigned 100 / 7 -> done after exactly 66 cycles; quotient=14, remainder=2, div_by_zero=0, busy high for 65 cycles.
2. Signed build: -100 / 7 -> quotient=-14, remainder=-2. 100 / -7 -> quotient=-14, remainder=2. -100 / -7 -> quotient=14, remainder=-2.
3. Divisor 0, dividend 0x1234 -> done after 1 cycle; quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234, div_by_zero=1. A following 9 / 3 clears the flag and gives 3 r 0.
4. Signed overflow 0x8000_0000_0000_0000 / -1 -> quotient=0x8000_0000_0000_0000, remainder=0. Unsigned 0xFFFF_FFFF_FFFF_FFFF / 1 -> quotient=all ones, remainder=0.
5. Robustness: start pulsed and operands changed at cycle 10 of RUN -> ignored, original result produced. rst_n pulsed low at cycle 30 -> all outputs 0 immediately (asynchronously), state IDLE, next start runs normally.
6. Back-to-back: start asserted in the DONE cycle with 1000 / 10 -> accepted, done drops next cycle, result 100 r 0 after 66 cycles.

Source files
------------

// File: rtl/divider_block_pkg.sv
// Shared arithmetic-unit constants for the divider: state encodings, default
// widths and the divide-by-zero quotient pattern.
package divider_block_pkg;

  localparam int DIV_WIDTH = 64;
  localparam int DIV_CNT_W = 7;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_FIX  = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/divider_step.sv
// One radix-2 non-restoring iteration: shift the dividend MSB into P, then
// subtract or add D depending on the sign of the previous P.
module divider_step
  import divider_block_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_p,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_p,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_d_ext;

  assign w_shift = {i_p[WIDTH-1:0], i_q_msb};
  assign w_d_ext = {1'b0, i_d};

  assign o_p     = i_p[WIDTH] ? (w_shift + w_d_ext) : (w_shift - w_d_ext);
  assign o_q_bit = ~o_p[WIDTH];

endmodule

// File: rtl/divider_block.sv
// Sequential radix-2 non-restoring divider with quotient/remainder outputs.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module divider_block
  import divider_block_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e       r_state;
  div_state_e       w_state_next;

  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_zero;

  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_accept;
  logic             w_run;
  logic             w_fix;
  logic             w_busy_next;
  logic             w_done_next;
  logic             w_zero;
  logic             w_last;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_p_next;
  logic             w_q_bit;
  logic [WIDTH:0]   w_p_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_zero = (divisor == '0);
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DIV_IDLE, DIV_DONE: begin
        if (start) begin
          w_state_next = w_zero ? DIV_DONE : DIV_RUN;
        end
      end
      DIV_RUN: begin
        if (w_last) begin
          w_state_next = DIV_FIX;
        end
      end
      DIV_FIX: w_state_next = DIV_DONE;
      default: w_state_next = DIV_IDLE;
    endcase
  end

  // Output/control decode; status flags are registered one cycle behind the state
  always_comb begin
    w_accept    = 1'b0;
    w_run       = 1'b0;
    w_fix       = 1'b0;
    w_busy_next = 1'b0;
    w_done_next = 1'b0;
    case (r_state)
      DIV_IDLE: w_accept = start;
      DIV_RUN: begin
        w_run       = 1'b1;
        w_busy_next = 1'b1;
      end
      DIV_FIX: begin
        w_fix       = 1'b1;
        w_busy_next = 1'b1;
      end
      DIV_DONE: begin
        w_accept    = start;
        w_done_next = ~start;
      end
      default: w_accept = 1'b0;
    endcase
  end

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_p     (r_p),
    .i_q_msb (r_q[WIDTH-1]),
    .i_d     (r_d),
    .o_p     (w_p_next),
    .o_q_bit (w_q_bit)
  );

  // Final restore step so the remainder magnitude is non-negative
  assign w_p_fix = r_p[WIDTH] ? (r_p + {1'b0, r_d}) : r_p;

`ifdef DIVIDER_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  assign w_dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign w_dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  assign w_quo_fix = r_neg_q ? (~r_q + 1'b1) : r_q;
  assign w_rem_fix = r_neg_r ? (~w_p_fix[WIDTH-1:0] + 1'b1) : w_p_fix[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_quo_fix = r_q;
  assign w_rem_fix = w_p_fix[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_busy <= w_busy_next;
      r_done <= w_done_next;
      r_dbz  <= w_done_next & r_zero;
      if (w_accept) begin
        r_p    <= '0;
        r_q    <= w_dvd_mag;
        r_d    <= w_dvs_mag;
        r_cnt  <= '0;
        r_zero <= w_zero;
        // Zero divisor skips the datapath entirely; results are fixed here
        if (w_zero) begin
          r_quotient  <= WIDTH'(DIV_ZERO_QUOTIENT);
          r_remainder <= dividend;
        end
      end else if (w_run) begin
        r_p   <= w_p_next;
        r_q   <= {r_q[WIDTH-2:0], w_q_bit};
        r_cnt <= r_cnt + 1'b1;
      end else if (w_fix) begin
        r_p         <= w_p_fix;
        r_quotient  <= w_quo_fix;
        r_remainder <= w_rem_fix;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;

endmodule

// File: tb/tb_divider_block.sv
// Self-checking bench for divider_block against an arithmetic reference model;
// follows DIVIDER_SIGNED_EN to pick signed or unsigned expectations.
module tb_divider_block;

  localparam int W = 64;
  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] MINV = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divider_block dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  // Reference: plain arithmetic division with the documented special cases
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
`ifdef DIVIDER_SIGNED_EN
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = ONES;
      r = a;
    end else if (a == MINV && b == ONES) begin
      q = MINV;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
`else
    if (b == '0) begin
      q = ONES;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
`endif
  endfunction

  // Drive one start at the current negedge, then wait (bounded) for done.
  // cycles = edges after the accept edge until done is seen, -1 on timeout.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int cycles, output int busy_cycles, output logic done0);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    done0       = done;
    cycles      = 0;
    busy_cycles = 0;
    while (cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cycles++;
      if (done) break;
    end
    if (!done) cycles = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got %b want 0", done); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    if (quotient !== '0)      begin errors++; $display("FAIL reset_quot got %h want 0", quotient); end
    if (remainder !== '0)     begin errors++; $display("FAIL reset_rem got %h want 0", remainder); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("txn reset: outputs checked");
  endtask

  task automatic test_basic();
    int cyc, bcyc;
    logic d0;
    run_div(64'd100, 64'd7, cyc, bcyc, d0);
    checks += 5;
    if (cyc != 66)            begin errors++; $display("FAIL basic_latency got %0d want 66", cyc); end
    if (bcyc != 65)           begin errors++; $display("FAIL basic_busy_cycles got %0d want 65", bcyc); end
    if (quotient !== 64'd14)  begin errors++; $display("FAIL basic_quot got %0d want 14", quotient); end
    if (remainder !== 64'd2)  begin errors++; $display("FAIL basic_rem got %0d want 2", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
    $display("txn 100/7 -> q=%0d r=%0d cycles=%0d busy=%0d", quotient, remainder, cyc, bcyc);
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed();
    logic signed [W-1:0] ta [3];
    logic signed [W-1:0] tb [3];
    logic signed [W-1:0] tq [3];
    logic signed [W-1:0] tr [3];
    int cyc, bcyc;
    logic d0;
    ta = '{-64'sd100, 64'sd100, -64'sd100};
    tb = '{64'sd7, -64'sd7, -64'sd7};
    tq = '{-64'sd14, -64'sd14, 64'sd14};
    tr = '{-64'sd2, 64'sd2, -64'sd2};
    for (int i = 0; i < 3; i++) begin
      run_div(ta[i], tb[i], cyc, bcyc, d0);
      checks += 3;
      if (cyc != 66)         begin errors++; $display("FAIL signed_latency[%0d] got %0d want 66", i, cyc); end
      if (quotient !== tq[i]) begin errors++; $display("FAIL signed_quot[%0d] got %h want %h", i, quotient, tq[i]); end
      if (remainder !== tr[i]) begin errors++; $display("FAIL signed_rem[%0d] got %h want %h", i, remainder, tr[i]); end
      $display("txn %0d/%0d -> q=%0d r=%0d", ta[i], tb[i], $signed(quotient), $signed(remainder));
    end
  endtask
`endif

  task automatic test_div_zero();
    int cyc, bcyc;
    logic d0;
    @(negedge clk);
    run_div(64'h1234, 64'd0, cyc, bcyc, d0);
    checks += 5;
    if (cyc != 1)                 begin errors++; $display("FAIL dbz_latency got %0d want 1", cyc); end
    if (bcyc != 0)                begin errors++; $display("FAIL dbz_busy_cycles got %0d want 0", bcyc); end
    if (quotient !== ONES)        begin errors++; $display("FAIL dbz_quot got %h want all ones", quotient); end
    if (remainder !== 64'h1234)   begin errors++; $display("FAIL dbz_rem got %h want 1234", remainder); end
    if (div_by_zero !== 1'b1)     begin errors++; $display("FAIL dbz_flag got %b want 1", div_by_zero); end
    $display("txn 0x1234/0 -> q=%h r=%h dbz=%b", quotient, remainder, div_by_zero);
    run_div(64'd9, 64'd3, cyc, bcyc, d0);
    checks += 4;
    if (cyc != 66)            begin errors++; $display("FAIL after_dbz_latency got %0d want 66", cyc); end
    if (quotient !== 64'd3)   begin errors++; $display("FAIL after_dbz_quot got %0d want 3", quotient); end
    if (remainder !== 64'd0)  begin errors++; $display("FAIL after_dbz_rem got %0d want 0", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL after_dbz_flag got %b want 0", div_by_zero); end
    $display("txn 9/3 -> q=%0d r=%0d dbz=%b", quotient, remainder, div_by_zero);
  endtask

  task automatic test_boundary();
    logic [W-1:0] ca [3];
    logic [W-1:0] cb [3];
    logic [W-1:0] eq, er;
    int cyc, bcyc;
    logic d0;
    ca = '{MINV, ONES, MINV};
    cb = '{ONES, 64'd1, 64'd1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      run_div(ca[i], cb[i], cyc, bcyc, d0);
      model(ca[i], cb[i], eq, er);
      checks += 4;
      if (cyc != 66)            begin errors++; $display("FAIL bound_latency[%0d] got %0d want 66", i, cyc); end
      if (quotient !== eq)      begin errors++; $display("FAIL bound_quot[%0d] got %h want %h", i, quotient, eq); end
      if (remainder !== er)     begin errors++; $display("FAIL bound_rem[%0d] got %h want %h", i, remainder, er); end
      if (div_by_zero !== 1'b0) begin errors++; $display("FAIL bound_dbz[%0d] got %b want 0", i, div_by_zero); end
      $display("txn %h/%h -> q=%h r=%h", ca[i], cb[i], quotient, remainder);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er;
    int cyc, bcyc, want_cyc;
    logic d0;
    for (int i = 0; i < 20; i++) begin
      a = {$urandom, $urandom};
      case (i % 4)
        0: b = {$urandom, $urandom};
        1: b = W'($urandom_range(1, 100));
        2: b = {$urandom, $urandom} >> $urandom_range(1, 62);
        default: b = (i == 7) ? '0 : W'($urandom_range(1, 5));
      endcase
      if ($urandom_range(0, 1) == 1 && i % 4 == 1) b = -b;
      model(a, b, eq, er);
      want_cyc = (b == '0) ? 1 : 66;
      @(negedge clk);
      run_div(a, b, cyc, bcyc, d0);
      checks += 4;
      if (cyc != want_cyc)            begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, cyc, want_cyc); end
      if (quotient !== eq)            begin errors++; $display("FAIL rand_quot[%0d] got %h want %h", i, quotient, eq); end
      if (remainder !== er)           begin errors++; $display("FAIL rand_rem[%0d] got %h want %h", i, remainder, er); end
      if (div_by_zero !== (b == '0))  begin errors++; $display("FAIL rand_dbz[%0d] got %b want %b", i, div_by_zero, b == '0); end
      $display("txn %h/%h -> q=%h r=%h", a, b, quotient, remainder);
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    @(negedge clk);
    dividend = 64'd100;
    divisor  = 64'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        dividend = 64'd5;
        divisor  = 64'd1;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    if (!done) cyc = -1;
    checks += 3;
    if (cyc != 66)           begin errors++; $display("FAIL ignore_latency got %0d want 66", cyc); end
    if (quotient !== 64'd14) begin errors++; $display("FAIL ignore_quot got %0d want 14", quotient); end
    if (remainder !== 64'd2) begin errors++; $display("FAIL ignore_rem got %0d want 2", remainder); end
    $display("txn 100/7 with start at run cycle 10 -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_reset_midrun();
    int cyc, bcyc;
    logic d0;
    @(negedge clk);
    dividend = 64'd1000;
    divisor  = 64'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (busy !== 1'b0)        begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    if (done !== 1'b0)        begin errors++; $display("FAIL midrst_done got %b want 0", done); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL midrst_dbz got %b want 0", div_by_zero); end
    if (quotient !== '0)      begin errors++; $display("FAIL midrst_quot got %h want 0", quotient); end
    if (remainder !== '0)     begin errors++; $display("FAIL midrst_rem got %h want 0", remainder); end
    $display("txn reset at run cycle 30: outputs cleared");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_div(64'd77, 64'd5, cyc, bcyc, d0);
    checks += 3;
    if (cyc != 66)           begin errors++; $display("FAIL postrst_latency got %0d want 66", cyc); end
    if (quotient !== 64'd15) begin errors++; $display("FAIL postrst_quot got %0d want 15", quotient); end
    if (remainder !== 64'd2) begin errors++; $display("FAIL postrst_rem got %0d want 2", remainder); end
    $display("txn 77/5 after reset -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    logic d0;
    @(negedge clk);
    run_div(64'd50, 64'd5, cyc, bcyc, d0);
    checks += 1;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", done); end
    run_div(64'd1000, 64'd10, cyc, bcyc, d0);
    checks += 4;
    if (d0 !== 1'b0)          begin errors++; $display("FAIL b2b_done_drop got %b want 0", d0); end
    if (cyc != 66)            begin errors++; $display("FAIL b2b_latency got %0d want 66", cyc); end
    if (quotient !== 64'd100) begin errors++; $display("FAIL b2b_quot got %0d want 100", quotient); end
    if (remainder !== 64'd0)  begin errors++; $display("FAIL b2b_rem got %0d want 0", remainder); end
    $display("txn 1000/10 back-to-back -> q=%0d r=%0d", quotient, remainder);
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef DIVIDER_SIGNED_EN
    test_signed();
`endif
    test_div_zero();
    test_boundary();
    test_random();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
